// File: rtl/wishbone_pkg.sv
// Shared types, widths and the byte-lane merge helper for the Wishbone SRAM responder.
package wishbone_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_SEL_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } wb_slave_state_t;

    // Lanes whose select bit is set take the new byte; the rest keep the old one.
    function automatic logic [WB_DATA_WIDTH-1:0] wb_apply_select(
        input logic [WB_DATA_WIDTH-1:0] old_word,
        input logic [WB_DATA_WIDTH-1:0] new_word,
        input logic [WB_SEL_WIDTH-1:0]  sel
    );
        logic [WB_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < WB_SEL_WIDTH; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// Word-organised single-port RAM with byte-lane writes and a registered read.
module byte_enable_ram
    import wishbone_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [WB_SEL_WIDTH-1:0]  sel,
    input  logic [ADDR_BITS-1:0]     addr,
    input  logic [WB_DATA_WIDTH-1:0] wdata,
    output logic [WB_DATA_WIDTH-1:0] rdata
);

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wb_apply_select(mem[addr], wdata, sel);
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wishbone_sram_slave.sv
// Wishbone responder for on-chip data SRAM with programmable wait states.
// Define WISHBONE_SLAVE_ERR_EN to terminate out-of-range accesses with o_err.
module wishbone_sram_slave
    import wishbone_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_cycle,
    input  logic                     i_strobe,
    input  logic                     i_write_enable,
    input  logic [ADDR_WIDTH-1:0]    i_address,
    input  logic [WB_SEL_WIDTH-1:0]  i_select,
    input  logic [WB_DATA_WIDTH-1:0] i_data,
    output logic [WB_DATA_WIDTH-1:0] o_data,
    output logic                     o_ack,
    output logic                     o_err
);

`ifdef WISHBONE_SLAVE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    localparam int unsigned         IDX_BITS  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] LIMIT     = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0]          WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_slave_state_t state, state_next;
    logic [3:0]      wait_cnt, wait_cnt_next;
    logic            req;
    logic            enter_respond;

    logic [ADDR_WIDTH-1:0] addr_off;
    logic [IDX_BITS-1:0]   req_index;
    logic                  req_in_range;
    logic                  addr_unused;

    logic                     lat_we;
    logic [IDX_BITS-1:0]      lat_index;
    logic [WB_SEL_WIDTH-1:0]  lat_sel;
    logic [WB_DATA_WIDTH-1:0] lat_data;
    logic                     lat_in_range;

    logic                     cur_we;
    logic [IDX_BITS-1:0]      cur_index;
    logic [WB_SEL_WIDTH-1:0]  cur_sel;
    logic [WB_DATA_WIDTH-1:0] cur_data;
    logic                     cur_in_range;

    logic                     ram_we;
    logic [WB_DATA_WIDTH-1:0] ram_rdata;
    logic                     ack_q;
    logic [WB_DATA_WIDTH-1:0] data_hold;

    assign req          = i_cycle & i_strobe;
    assign addr_off     = i_address - BASE_ADDR;
    assign req_index    = addr_off[IDX_BITS+1:2];
    assign req_in_range = ({1'b0, i_address} >= {1'b0, BASE_ADDR}) && ({1'b0, i_address} < LIMIT);
    assign addr_unused  = ^addr_off;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        enter_respond = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next    = RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == '0) begin
                    state_next    = RESPOND;
                    enter_respond = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the RESPOND edge is the acceptance edge, so the
    // RAM must see the live bus request rather than the latched copy.
    always_comb begin
        cur_we       = lat_we;
        cur_index    = lat_index;
        cur_sel      = lat_sel;
        cur_data     = lat_data;
        cur_in_range = lat_in_range;
        if (state == IDLE) begin
            cur_we       = i_write_enable;
            cur_index    = req_index;
            cur_sel      = i_select;
            cur_data     = i_data;
            cur_in_range = req_in_range;
        end
    end

    assign ram_we = enter_respond && cur_we && cur_in_range && !reset;

    byte_enable_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (IDX_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .sel   (cur_sel),
        .addr  (cur_index),
        .wdata (cur_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            lat_we       <= i_write_enable;
            lat_index    <= req_index;
            lat_sel      <= i_select;
            lat_data     <= i_data;
            lat_in_range <= req_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ack_q     <= 1'b0;
            data_hold <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ack_q    <= enter_respond && (cur_in_range || !ERR_EN);
            if (state == RESPOND) begin
                data_hold <= o_data;
            end
        end
    end

    // The read word comes straight from the RAM register during RESPOND and
    // is captured into data_hold on the way out so it persists afterwards.
    always_comb begin
        o_data = data_hold;
        if (state == RESPOND && !lat_we) begin
            if (lat_in_range) begin
                o_data = ram_rdata;
            end else if (!ERR_EN) begin
                o_data = '0;
            end
        end
    end

    assign o_ack = ack_q;

`ifdef WISHBONE_SLAVE_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= enter_respond && !cur_in_range;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// Self-checking bench: three responders with 0, 1 and 3 wait states against a reference model.
module tb_wishbone_sram_slave;

    localparam int NI = 3;
    localparam int unsigned WS    [NI] = '{0, 1, 3};
    localparam logic [31:0] BASE  [NI] = '{32'h0000_0000, 32'h0000_0000, 32'h0001_0000};
    localparam int unsigned DEPTH [NI] = '{16, 4096, 64};

`ifdef WISHBONE_SLAVE_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cyc   [NI];
    logic        stb   [NI];
    logic        we    [NI];
    logic [31:0] adr   [NI];
    logic [3:0]  sel   [NI];
    logic [31:0] dat_w [NI];
    logic [31:0] dat_r [NI];
    logic        ack   [NI];
    logic        err   [NI];

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] model_mem [longint];
    logic [31:0] model_hold [NI];

    always #5 clk = ~clk;

    wishbone_sram_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH[0]), .BASE_ADDR(BASE[0]), .WAIT_STATES(WS[0])) dut0 (
        .clk(clk), .reset(reset), .i_cycle(cyc[0]), .i_strobe(stb[0]), .i_write_enable(we[0]),
        .i_address(adr[0]), .i_select(sel[0]), .i_data(dat_w[0]), .o_data(dat_r[0]), .o_ack(ack[0]), .o_err(err[0]));

    wishbone_sram_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH[1]), .BASE_ADDR(BASE[1]), .WAIT_STATES(WS[1])) dut1 (
        .clk(clk), .reset(reset), .i_cycle(cyc[1]), .i_strobe(stb[1]), .i_write_enable(we[1]),
        .i_address(adr[1]), .i_select(sel[1]), .i_data(dat_w[1]), .o_data(dat_r[1]), .o_ack(ack[1]), .o_err(err[1]));

    wishbone_sram_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH[2]), .BASE_ADDR(BASE[2]), .WAIT_STATES(WS[2])) dut2 (
        .clk(clk), .reset(reset), .i_cycle(cyc[2]), .i_strobe(stb[2]), .i_write_enable(we[2]),
        .i_address(adr[2]), .i_select(sel[2]), .i_data(dat_w[2]), .o_data(dat_r[2]), .o_ack(ack[2]), .o_err(err[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic in_range(input int k, input logic [31:0] a);
        return (longint'(a) >= longint'(BASE[k])) &&
               (longint'(a) < longint'(BASE[k]) + 4 * longint'(DEPTH[k]));
    endfunction

    function automatic longint mkey(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE[k];
        return (longint'(k) << 32) | longint'(off >> 2);
    endfunction

    // Memory as a map of words; a transfer either updates selected bytes or reads a word.
    task automatic model_xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, output logic e_ack, output logic e_err,
                              output logic [31:0] e_q);
        logic [31:0] word;
        logic        inr;
        inr   = in_range(k, a);
        e_ack = 1'b1;
        e_err = 1'b0;
        if (!inr && ERR) begin
            e_ack = 1'b0;
            e_err = 1'b1;
        end else if (w) begin
            if (inr) begin
                word = model_mem.exists(mkey(k, a)) ? model_mem[mkey(k, a)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                model_mem[mkey(k, a)] = word;
            end
        end else begin
            model_hold[k] = inr ? model_mem[mkey(k, a)] : 32'h0;
        end
        e_q = model_hold[k];
    endtask

    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int lat, output logic g_ack, output logic g_err,
                        output logic [31:0] g_q);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_w[k] = d;
        lat = -1; g_ack = 1'b0; g_err = 1'b0; g_q = '0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) begin
                lat = e; g_ack = ack[k]; g_err = err[k]; g_q = dat_r[k];
                break;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
    endtask

    task automatic run_check(input string tag, input int k, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d, input logic e_ack,
                             input logic e_err, input logic [31:0] e_q);
        int          lat;
        logic        g_ack, g_err;
        logic [31:0] g_q;
        xfer(k, w, a, s, d, lat, g_ack, g_err, g_q);
        check({tag, " latency"}, 32'(lat), 32'(WS[k] + 1));
        check({tag, " ack"}, 32'(g_ack), 32'(e_ack));
        check({tag, " err"}, 32'(g_err), 32'(e_err));
        check({tag, " data"}, g_q, e_q);
        @(posedge clk); #1;
        check({tag, " single pulse"}, 32'({ack[k], err[k]}), 32'h0);
        check({tag, " data hold"}, dat_r[k], e_q);
    endtask

    typedef struct {
        int          k;
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        ack;
        logic        err;
        logic [31:0] q;
    } vec_t;

    vec_t vecs [21];

    initial begin
        logic        e_ack, e_err;
        logic [31:0] e_q;
        logic [31:0] pool [8];
        logic [31:0] a;
        logic        w;
        int          n_ack;

        vecs[0]  = '{1, 1'b1, 32'h0000_2000, 4'hF, 32'hCAFE_BABE, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1, 1'b0, 32'h0000_2000, 4'hF, 32'h0,         1'b1, 1'b0, 32'hCAFE_BABE};
        vecs[2]  = '{1, 1'b1, 32'h0000_2004, 4'hF, 32'h1122_3344, 1'b1, 1'b0, 32'hCAFE_BABE};
        vecs[3]  = '{1, 1'b1, 32'h0000_2004, 4'h5, 32'hAABB_CCDD, 1'b1, 1'b0, 32'hCAFE_BABE};
        vecs[4]  = '{1, 1'b0, 32'h0000_2004, 4'hF, 32'h0,         1'b1, 1'b0, 32'h11BB_33DD};
        vecs[5]  = '{1, 1'b1, 32'h0000_2004, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h11BB_33DD};
        vecs[6]  = '{1, 1'b0, 32'h0000_2004, 4'hF, 32'h0,         1'b1, 1'b0, 32'h11BB_33DD};
        vecs[7]  = '{1, 1'b1, 32'h0000_0000, 4'hF, 32'h0101_0101, 1'b1, 1'b0, 32'h11BB_33DD};
        vecs[8]  = '{1, 1'b0, 32'h0000_4000, 4'hF, 32'h0,         !ERR, ERR, ERR ? 32'h11BB_33DD : 32'h0};
        vecs[9]  = '{1, 1'b1, 32'h0000_4000, 4'hF, 32'hDEAD_DEAD, !ERR, ERR, ERR ? 32'h11BB_33DD : 32'h0};
        vecs[10] = '{1, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0101_0101};
        vecs[11] = '{1, 1'b1, 32'h0000_3FFC, 4'hF, 32'h600D_F00D, 1'b1, 1'b0, 32'h0101_0101};
        vecs[12] = '{1, 1'b0, 32'h0000_3FFC, 4'hF, 32'h0,         1'b1, 1'b0, 32'h600D_F00D};
        vecs[13] = '{2, 1'b1, 32'h0001_0000, 4'hF, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{2, 1'b1, 32'h0001_00FC, 4'hF, 32'hA5A5_003F, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{2, 1'b0, 32'h0001_00FC, 4'hF, 32'h0,         1'b1, 1'b0, 32'hA5A5_003F};
        vecs[16] = '{2, 1'b0, 32'h0000_FFFC, 4'hF, 32'h0,         !ERR, ERR, ERR ? 32'hA5A5_003F : 32'h0};
        vecs[17] = '{2, 1'b0, 32'h0001_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001};
        vecs[18] = '{2, 1'b0, 32'h0001_0100, 4'hF, 32'h0,         !ERR, ERR, ERR ? 32'hA5A5_0001 : 32'h0};
        vecs[19] = '{0, 1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0};
        vecs[20] = '{0, 1'b1, 32'h0000_0004, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0};

        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; sel[k] = '0; dat_w[k] = '0;
            model_hold[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset ack%0d", k), 32'(ack[k]), 32'h0);
            check($sformatf("reset err%0d", k), 32'(err[k]), 32'h0);
            check($sformatf("reset data%0d", k), dat_r[k], 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            model_xfer(vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, e_ack, e_err, e_q);
            run_check($sformatf("vec%0d", i), vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d,
                      vecs[i].ack, vecs[i].err, vecs[i].q);
        end

        // Zero wait states, strobe held across both reads.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0; sel[0] = 4'hF;
        @(posedge clk); #1;
        check("b2b ack0", 32'(ack[0]), 32'h1);
        check("b2b data0", dat_r[0], 32'h0BAD_F00D);
        adr[0] = 32'h4;
        @(posedge clk); #1;
        check("b2b gap", 32'(ack[0]), 32'h0);
        @(posedge clk); #1;
        check("b2b ack1", 32'(ack[0]), 32'h1);
        check("b2b data1", dat_r[0], 32'h1234_5678);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        check("b2b no extra ack", 32'(ack[0]), 32'h0);
        model_hold[0] = 32'h1234_5678;

        // Strobe dropped while waiting: nothing may happen.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h0001_0000; sel[2] = 4'hF; dat_w[2] = 32'hFFFF_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        n_ack = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[2] || err[2]) n_ack++;
        end
        check("abort no ack", 32'(n_ack), 32'h0);
        check("abort data", dat_r[2], model_hold[2]);
        run_check("abort readback", 2, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 1'b1, 1'b0, 32'hA5A5_0001);
        model_hold[2] = 32'hA5A5_0001;

        // Reset in the middle of a waiting write.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h0001_00FC; sel[2] = 4'hF; dat_w[2] = 32'h1212_1212;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset mid-wait ack", 32'(ack[2]), 32'h0);
        check("reset mid-wait err", 32'(err[2]), 32'h0);
        check("reset mid-wait data", dat_r[2], 32'h0);
        check("reset other data", dat_r[1], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int k = 0; k < NI; k++) model_hold[k] = '0;
        run_check("reset readback", 2, 1'b0, 32'h0001_00FC, 4'hF, 32'h0, 1'b1, 1'b0, 32'hA5A5_003F);
        model_hold[2] = 32'hA5A5_003F;

        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 8; p++) begin
                pool[p] = BASE[k] + 4 * $urandom_range(0, DEPTH[k] - 1);
                model_xfer(k, 1'b1, pool[p], 4'hF, $urandom, e_ack, e_err, e_q);
            end
            for (int p = 0; p < 8; p++) begin
                run_check($sformatf("preload k%0d p%0d", k, p), k, 1'b1, pool[p], 4'hF,
                          model_mem[mkey(k, pool[p])], 1'b1, 1'b0, model_hold[k]);
            end
            for (int t = 0; t < 30; t++) begin
                logic [3:0]  s;
                logic [31:0] d;
                if ($urandom_range(0, 7) == 0) a = BASE[k] + 4 * DEPTH[k] + 4 * $urandom_range(0, 3);
                else a = pool[$urandom_range(0, 7)];
                w = 1'($urandom);
                s = 4'($urandom);
                d = $urandom;
                model_xfer(k, w, a, s, d, e_ack, e_err, e_q);
                run_check($sformatf("rand k%0d t%0d a=%h", k, t, a), k, w, a, s, d, e_ack, e_err, e_q);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
